data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 93 +++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: SRAM responder with in-order completion after a minimum latency.
// Define RESP_RAND_STALL_EN to add pseudo-random LFSR stalls on both handshakes.
module data_sram_resp #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    logic [31:0]       mem_q [2**MEM_AW];
    logic [3:0]        wr_q, wr_d;
    logic [31:0]       rd_q [4];
    logic [31:0]       rd_d [4];
    logic [2:0]        cd_q [4];
    logic [2:0]        cd_d [4];
    logic [1:0]        hd_q, hd_d, tl_q, tl_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] widx;
    logic              addr_stall, data_stall, push, pop;
    logic              unused_ok;

`ifdef RESP_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk) lfsr_q <= reset ? 16'hACE1 : lfsr_d;
    assign addr_stall = lfsr_q[0] & lfsr_q[1];
    assign data_stall = lfsr_q[2] & lfsr_q[3];
`else
    assign addr_stall = 1'b0;
    assign data_stall = 1'b0;
`endif

    // Size and the bits outside the word index do not affect behaviour.
    assign unused_ok = ^{data_sram_size, data_sram_addr};
    assign widx = data_sram_addr[MEM_AW+1:2];

    // Acceptance looks only at the registered count, never at this cycle's pop.
    assign data_sram_addr_ok = !reset && data_sram_req && cnt_q < 3'(MAX_OUT) && !addr_stall;
    assign data_sram_data_ok = !reset && cnt_q != 3'd0 && cd_q[hd_q] == 3'd0 && !data_stall;
    assign data_sram_rdata   = (data_sram_data_ok && !wr_q[hd_q]) ? rd_q[hd_q] : 32'h0;
    assign push = data_sram_addr_ok;
    assign pop  = data_sram_data_ok;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(MAX_OUT - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign hd_d  = pop ? nxt(hd_q) : hd_q;
    assign tl_d  = push ? nxt(tl_q) : tl_q;
    assign cnt_d = cnt_q + 3'(push) - 3'(pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        for (int i = 0; i < 4; i++) cd_d[i] = cd_q[i] - 3'(cd_q[i] != 3'd0);
        if (push) begin
            wr_d[tl_q] = data_sram_wr;
            rd_d[tl_q] = data_sram_wr ? 32'h0 : mem_q[widx];
            cd_d[tl_q] = 3'(LATENCY - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 3'd0;
            hd_q  <= 2'd0;
            tl_q  <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            hd_q  <= hd_d;
            tl_q  <= tl_d;
        end
        wr_q <= wr_d;
        rd_q <= rd_d;
        cd_q <= cd_d;
    end

    always_ff @(posedge clk) begin
        if (push && data_sram_wr)
            for (int i = 0; i < 4; i++)
                if (data_sram_wstrb[i]) mem_q[widx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
endmodule
